// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Holds the bus widths, the ownership FSM encoding and the requester indices.
package mem_pkg;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU port, the debug/loader port and the dmem port.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
  parameter int AW = mem_pkg::AW,
  parameter int DW = mem_pkg::DW
) ();

  logic          m0_req;
  logic          m0_we;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie, the requester that did
// not win last time is chosen.
module rr_pick2
  import mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = 2'b00;
      if (last_i == 1'b1) gnt_o[REQ_CPU] = 1'b1;
      else                gnt_o[REQ_DBG] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one combinational-read data memory between the CPU (m0) and the
// debug/loader port (m1) with locked ownership and registered read return.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int AW = mem_pkg::AW,
  parameter int DW = mem_pkg::DW
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  arb_state_t    state_q, state_d;
  logic          last_q, last_d;
  logic [1:0]    req, pick_gnt, gnt;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          m0_rvalid_q, m1_rvalid_q;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;

  assign req = {bus.m1_req, bus.m0_req};

  rr_pick2 u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick_gnt)
  );

  // Grants are held low while reset is asserted so nothing reaches memory.
  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      case (state_q)
        IDLE:    gnt = pick_gnt;
        OWN0:    gnt[REQ_CPU] = bus.m0_req;
        OWN1:    gnt[REQ_DBG] = bus.m1_req;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign sel_addr      = gnt[REQ_DBG] ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata     = gnt[REQ_DBG] ? bus.m1_wdata : bus.m0_wdata;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;
  assign bus.mem_we    = (gnt[REQ_CPU] & bus.m0_we) | (gnt[REQ_DBG] & bus.m1_we);
  assign bus.m0_gnt    = gnt[REQ_CPU];
  assign bus.m1_gnt    = gnt[REQ_DBG];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (gnt != 2'b00) last_d = gnt[REQ_DBG];
    case (state_q)
      IDLE: begin
        if (gnt[REQ_CPU] && bus.m0_lock)      state_d = OWN0;
        else if (gnt[REQ_DBG] && bus.m1_lock) state_d = OWN1;
      end
      OWN0:    if (!(bus.m0_req && bus.m0_lock)) state_d = IDLE;
      OWN1:    if (!(bus.m1_req && bus.m1_lock)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      m0_rvalid_q <= gnt[REQ_CPU] & ~bus.m0_we;
      m1_rvalid_q <= gnt[REQ_DBG] & ~bus.m1_we;
      if (gnt[REQ_CPU] && !bus.m0_we) m0_rdata_q <= bus.mem_rdata;
      if (gnt[REQ_DBG] && !bus.m1_we) m1_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a small word RAM model serves the memory
// side; every expected value below is worked out by hand from the behaviour.
module tb_dmem_arbiter;
  import mem_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [31:0] ram [0:63];

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = ram[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic lock,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lock;
    bus.m0_addr = addr; bus.m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic lock,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock;
    bus.m1_addr = addr; bus.m1_wdata = wdata;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    drive_m0(0, 0, 0, 0, 0);
    drive_m1(0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) ram[i] = '0;
    ram[25] = 32'h0000_00A5;

    // Reset state; a request during reset must not be granted.
    repeat (2) step();
    drive_m0(1, 0, 0, 96, 0);
    #1;
    check("rst_m0_gnt", bus.m0_gnt, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_m0_rvalid", bus.m0_rvalid, 0);
    check("rst_m0_rdata", bus.m0_rdata, 0);
    check("rst_state", dut.state_q, IDLE);
    drive_m0(0, 0, 0, 0, 0);
    @(negedge clk) reset = 1'b1;
    step();

    // m0 store 96 = 7.
    drive_m0(1, 1, 0, 96, 7);
    #1;
    check("st_m0_gnt", bus.m0_gnt, 1);
    check("st_mem_we", bus.mem_we, 1);
    check("st_mem_addr", bus.mem_addr, 96);
    check("st_mem_wdata", bus.mem_wdata, 7);
    step();
    check("st_ram24", ram[24], 7);
    check("st_no_rvalid", bus.m0_rvalid, 0);

    // m0 load 96 -> 7 one cycle later.
    bus.m0_we = 1'b0;
    #1;
    check("ld_m0_gnt", bus.m0_gnt, 1);
    check("ld_mem_we", bus.mem_we, 0);
    step();
    check("ld_m0_rvalid", bus.m0_rvalid, 1);
    check("ld_m0_rdata", bus.m0_rdata, 7);
    check("ld_m1_rvalid", bus.m1_rvalid, 0);
    bus.m0_req = 1'b0;
    step();
    check("ld_pulse", bus.m0_rvalid, 0);
    check("ld_hold", bus.m0_rdata, 7);

    // Round robin after reset: m0 96 (7), m1 100 (A5), alternating.
    reset = 1'b0;
    step();
    drive_m0(1, 0, 0, 96, 0);
    drive_m1(1, 0, 0, 100, 0);
    @(negedge clk) reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_m0_gnt", bus.m0_gnt, (i % 2 == 0) ? 1 : 0);
      check("rr_m1_gnt", bus.m1_gnt, (i % 2 == 1) ? 1 : 0);
      check("rr_excl", bus.m0_gnt & bus.m1_gnt, 0);
      step();
      check("rr_m0_rvalid", bus.m0_rvalid, (i % 2 == 0) ? 1 : 0);
      check("rr_m1_rvalid", bus.m1_rvalid, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) check("rr_m0_rdata", bus.m0_rdata, 7);
      else            check("rr_m1_rdata", bus.m1_rdata, 32'hA5);
    end
    drive_m0(0, 0, 0, 0, 0);
    drive_m1(0, 0, 0, 0, 0);

    // m0 alone once, so m1 wins the next tie.
    drive_m0(1, 0, 0, 96, 0);
    #1;
    check("pre_m0_gnt", bus.m0_gnt, 1);
    step();
    check("pre_m0_rvalid", bus.m0_rvalid, 1);

    // m1 locked burst 100=7 (lock) then 104=9 (unlock), m0 waiting.
    drive_m1(1, 1, 1, 100, 7);
    #1;
    check("lk1_m1_gnt", bus.m1_gnt, 1);
    check("lk1_m0_gnt", bus.m0_gnt, 0);
    check("lk1_mem_addr", bus.mem_addr, 100);
    check("lk1_mem_we", bus.mem_we, 1);
    step();
    check("lk1_state", dut.state_q, OWN1);
    drive_m1(1, 1, 0, 104, 9);
    #1;
    check("lk2_m1_gnt", bus.m1_gnt, 1);
    check("lk2_m0_gnt", bus.m0_gnt, 0);
    check("lk2_mem_addr", bus.mem_addr, 104);
    step();
    check("lk2_state", dut.state_q, IDLE);
    drive_m1(0, 0, 0, 0, 0);
    #1;
    check("lk3_m0_gnt", bus.m0_gnt, 1);
    check("lk_ram25", ram[25], 7);
    check("lk_ram26", ram[26], 9);
    step();
    check("lk3_m0_rvalid", bus.m0_rvalid, 1);
    check("lk3_m0_rdata", bus.m0_rdata, 7);

    // m1 takes OWN1 then drops req; m0 store 108 waits one idle cycle.
    drive_m0(1, 1, 0, 108, 32'h33);
    drive_m1(1, 0, 1, 104, 0);
    #1;
    check("dr_m1_gnt", bus.m1_gnt, 1);
    check("dr_m0_gnt", bus.m0_gnt, 0);
    step();
    check("dr_state_own", dut.state_q, OWN1);
    check("dr_m1_rvalid", bus.m1_rvalid, 1);
    check("dr_m1_rdata", bus.m1_rdata, 9);
    bus.m1_req = 1'b0;
    #1;
    check("dr_idle_m0_gnt", bus.m0_gnt, 0);
    check("dr_idle_m1_gnt", bus.m1_gnt, 0);
    check("dr_idle_mem_we", bus.mem_we, 0);
    step();
    check("dr_state_idle", dut.state_q, IDLE);
    check("dr_m1_pulse", bus.m1_rvalid, 0);
    check("dr_ram27_untouched", ram[27], 0);
    bus.m1_lock = 1'b0;
    #1;
    check("dr_m0_gnt", bus.m0_gnt, 1);
    check("dr_mem_we", bus.mem_we, 1);
    check("dr_mem_addr", bus.mem_addr, 108);
    step();
    check("dr_ram27", ram[27], 32'h33);
    check("dr_m0_no_rvalid", bus.m0_rvalid, 0);
    drive_m0(0, 0, 0, 0, 0);

    // Locked m0 load, then reset right after the grant edge.
    drive_m0(1, 0, 1, 96, 0);
    #1;
    check("rs_m0_gnt", bus.m0_gnt, 1);
    step();
    check("rs_m0_rvalid", bus.m0_rvalid, 1);
    check("rs_state_own", dut.state_q, OWN0);
    drive_m1(1, 0, 0, 100, 0);
    reset = 1'b0;
    #1;
    check("rs_clr_rvalid", bus.m0_rvalid, 0);
    check("rs_clr_rdata", bus.m0_rdata, 0);
    check("rs_clr_state", dut.state_q, IDLE);
    check("rs_m1_gnt", bus.m1_gnt, 0);
    bus.m0_lock = 1'b0;
    @(negedge clk) reset = 1'b1;
    #1;
    check("rs_first_m0_gnt", bus.m0_gnt, 1);
    check("rs_first_m1_gnt", bus.m1_gnt, 0);
    step();
    check("rs_first_rvalid", bus.m0_rvalid, 1);
    check("rs_first_rdata", bus.m0_rdata, 7);
    drive_m0(0, 0, 0, 0, 0);
    drive_m1(0, 0, 0, 0, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single data memory (dmem) between the CPU load/store port (m0) and a debug/loader port (m1).
- Sits between `cpu` and `dmem` inside `top`.
- Forwards at most one access per cycle to memory and registers read data back to the winning requester.
- The CPU uses `m0_gnt` low as its memory stall.

Parameters:
- AW, 32, byte-address width; memory word index = addr[AW-1:2]
- DW, 32, data width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  CPU access request
- m0_we  in  1  CPU write enable (1 = store, 0 = load)
- m0_lock  in  1  CPU holds ownership after this access
- m0_addr  in  AW  CPU byte address
- m0_wdata  in  DW  CPU store data
- m0_gnt  out  1  CPU access accepted this cycle
- m0_rvalid  out  1  CPU load data valid
- m0_rdata  out  DW  CPU load data
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for the debug/loader port
- mem_we  out  1  write strobe to dmem
- mem_addr  out  AW  byte address to dmem
- mem_wdata  out  DW  write data to dmem
- mem_rdata  in  DW  dmem combinational read data

Behaviour:
- Reset (reset=0, async): state=IDLE, last=1 (so m0 wins first), m0/m1_rvalid=0, m0/m1_rdata=0. Grants are combinational and therefore 0 while in reset.
- State machine: IDLE, OWN0, OWN1.
- Grant (combinational, same cycle as req):
  - IDLE, one requester: grant it.
  - IDLE, both requesting: grant the requester not equal to `last` (round-robin).
  - OWN0: grant only m0; m1_gnt=0 regardless of m1_req. OWN1 is symmetric.
- Invariant: m0_gnt & m1_gnt is never 1.
- Memory drive:
  - mem_addr and mem_wdata follow the granted requester; they follow m0 when nothing is granted.
  - mem_we = granted requester's `we` AND its `gnt`; mem_we is never 1 without a grant.
- On each granted cycle (clk edge):
  - last <= granted index.
  - If we=0: mN_rdata <= mem_rdata and mN_rvalid <= 1 for the granted port only.
  - All other rvalid <= 0. rvalid is a single-cycle pulse; rdata holds its value until the next load by that port.
- Read latency: exactly 1 cycle from grant to rvalid. Writes have no response.
- State transitions:
  - IDLE -> OWNn when port n is granted with mN_lock=1.
  - OWNn stays while mN_req & mN_lock.
  - OWNn -> IDLE when owner issues an access with lock=0; that access completes and ownership is released after it.
  - OWNn -> IDLE when owner drops req; no access that cycle. Another requester may win from the next cycle.
- A non-owner request while in OWNn waits; it is not dropped. The requester holds req/addr/we/wdata stable until gnt.
- Back-to-back: a port granted in consecutive cycles gets one rvalid per load, in order.
- Reset asserted mid-operation: pending rvalid is cleared, ownership is released, and no stale rdata is delivered.

Decomposition:
- Shared package `mem_pkg`:
  - Constants AW and DW.
  - State encoding: arb_state_t {IDLE=2'd0, OWN0=2'd1, OWN1=2'd2}.
  - Requester index constants REQ_CPU=0, REQ_DBG=1.
- One sub-module, `rr_pick2`: combinational 2-way round-robin picker (req[1:0], last -> gnt[1:0]).
- State register, `last` pointer and response registers stay in dmem_arbiter.

Test Plan:
- Reset then m0 STR addr=96, wdata=7 (m1 idle) -> m0_gnt=1 the same cycle; mem_we=1, mem_addr=96; RAM[24]=7 next edge; m0_rvalid stays 0.
- m0 LDR addr=96 after the above -> m0_gnt=1; m0_rvalid=1 exactly one cycle later with m0_rdata=7; m1_rvalid=0.
- Both req continuously, loads to 96 (m0) and 100 (m1), right after reset -> grants alternate m0, m1, m0, m1; never both; each rvalid one cycle after its grant.
- m1 writes 100=7 and 104=9 with lock=1 then lock=0 while m0 requests throughout -> m0_gnt=0 for both m1 beats; m0 granted on the cycle after m1's lock=0 beat; RAM[25]=7, RAM[26]=9.
- m1 takes OWN1 with lock=1 then drops req -> state returns to IDLE with no memory access that cycle; a pending m0 request is granted next cycle.
- Assert reset the cycle after an m0 load grant -> m0_rvalid=0, m0_rdata=0, state=IDLE; first grant after release goes to m0 when both request.
